// File: rtl/jt49_multi.sv
// jt49_multi - parametrised multi-channel PSG core.
//
// CH square-wave tone channels, one shared 17-bit LFSR noise source and one
// shared AY-shaped envelope generator. All are programmed through a 32-entry
// register bus. The core produces a time-multiplexed mixed sum together with
// the linear amplitude of each channel.
//
// Parameters:
//   CH      number of tone channels, 1..8
//   TW      tone period width in bits, 9..16
//   CLKDIV  tone prescaler is 2^CLKDIV cen pulses, 1..8
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   cen           clock enable for all sound logic (the bus ignores it)
//   cs_n, wr_n    active-low chip select / write strobe
//   addr, din     register address / write data
//   dout          registered read data, valid the clk after a read
//   sound         mixed sum of all channel amplitudes (0..2040)
//   ch_out        per-channel amplitude, channel k at [8k+7:8k]
//   sample_valid  one-clk pulse when sound and ch_out update
module jt49_multi #(
  parameter int CH     = 3,
  parameter int TW     = 12,
  parameter int CLKDIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            cs_n,
  input  logic            wr_n,
  input  logic [4:0]      addr,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  output logic [10:0]     sound,
  output logic [8*CH-1:0] ch_out,
  output logic            sample_valid
);

  localparam int SW = $clog2(CH + 1);

  typedef enum logic [1:0] {
    ENV_HOLD,
    ENV_UP,
    ENV_DOWN
  } env_st_e;

  // ---------------------------------------------------------------- registers
  logic [TW-1:0]  per_q [CH];
  logic [4:0]     vol_q [CH];
  logic [4:0]     nper_q;
  logic [CH-1:0]  tone_en_q;
  logic [CH-1:0]  noise_en_q;
  logic [15:0]    eper_q;
  logic [3:0]     shape_q;
  logic [7:0]     dout_q;
  logic [7:0]     rdata;

  logic we, rd, shape_wr;

  assign we       = ~cs_n & ~wr_n;
  assign rd       = ~cs_n &  wr_n;
  assign shape_wr = we && (addr == 5'h1D);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CH; i++) begin
        per_q[i] <= '0;
        vol_q[i] <= '0;
      end
      nper_q     <= '0;
      tone_en_q  <= '0;
      noise_en_q <= '0;
      eper_q     <= '0;
      shape_q    <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < CH; i++) begin
        if (addr == 5'(2 * i))      per_q[i][7:0]    <= din;
        if (addr == 5'(2 * i + 1))  per_q[i][TW-1:8] <= din[TW-9:0];
        if (addr == 5'(16 + i))     vol_q[i]         <= din[4:0];
      end
      case (addr)
        5'h18:   nper_q        <= din[4:0];
        5'h19:   tone_en_q     <= din[CH-1:0];
        5'h1A:   noise_en_q    <= din[CH-1:0];
        5'h1B:   eper_q[7:0]   <= din;
        5'h1C:   eper_q[15:8]  <= din;
        5'h1D:   shape_q       <= din[3:0];
        default: ;
      endcase
    end
  end

  // Addresses of absent channels never match inside the loop and fall
  // through to the 0x00 default.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (addr == 5'(2 * i))     rdata = per_q[i][7:0];
      if (addr == 5'(2 * i + 1)) rdata = 8'(per_q[i][TW-1:8]);
      if (addr == 5'(16 + i))    rdata = {3'b000, vol_q[i]};
    end
    case (addr)
      5'h18:   rdata = {3'b000, nper_q};
      5'h19:   rdata = 8'(tone_en_q);
      5'h1A:   rdata = 8'(noise_en_q);
      5'h1B:   rdata = eper_q[7:0];
      5'h1C:   rdata = eper_q[15:8];
      5'h1D:   rdata = {4'b0000, shape_q};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  dout_q <= '0;
    else if (rd) dout_q <= rdata;
  end

  // --------------------------------------------------------------- prescaler
  logic [CLKDIV-1:0] pre_q;
  logic [3:0]        epre_q;
  logic              tone_tick, env_tick;

  assign tone_tick = cen & (&pre_q);
  assign env_tick  = tone_tick & (&epre_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q  <= '0;
      epre_q <= '0;
    end else begin
      if (cen)       pre_q  <= pre_q + CLKDIV'(1);
      if (tone_tick) epre_q <= epre_q + 4'd1;
    end
  end

  // ------------------------------------------------------------ tone channels
  logic [TW-1:0] per_m1 [CH];
  logic [TW-1:0] tcnt_q [CH];
  logic [CH-1:0] tone_q;

  // Period 0 behaves as period 1, so the terminal count is max(P,1)-1.
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      per_m1[i] = (per_q[i] == '0) ? '0 : per_q[i] - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CH; i++) tcnt_q[i] <= '0;
      tone_q <= '0;
    end else if (tone_tick) begin
      for (int unsigned i = 0; i < CH; i++) begin
        if (tcnt_q[i] >= per_m1[i]) begin
          tcnt_q[i] <= '0;
          tone_q[i] <= ~tone_q[i];
        end else begin
          tcnt_q[i] <= tcnt_q[i] + TW'(1);
        end
      end
    end
  end

  // ------------------------------------------------------------------- noise
  logic [4:0]  nper_m1;
  logic [4:0]  ndiv_q;
  logic [16:0] lfsr_q;

  assign nper_m1 = (nper_q == '0) ? '0 : nper_q - 5'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ndiv_q <= '0;
      lfsr_q <= 17'h1;
    end else if (tone_tick) begin
      if (ndiv_q >= nper_m1) begin
        ndiv_q <= '0;
        lfsr_q <= {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
      end else begin
        ndiv_q <= ndiv_q + 5'd1;
      end
    end
  end

  // ---------------------------------------------------------------- envelope
  env_st_e     env_st_q, env_st_d;
  logic [3:0]  env_q, env_d;
  logic [15:0] ediv_q, ediv_d;
  logic [15:0] eper_m1;
  logic        env_step, env_up, env_at_end;

  assign eper_m1 = (eper_q == '0) ? '0 : eper_q - 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      env_st_q <= ENV_HOLD;
      env_q    <= '0;
      ediv_q   <= '0;
    end else begin
      env_st_q <= env_st_d;
      env_q    <= env_d;
      ediv_q   <= ediv_d;
    end
  end

  // A shape write restarts from din directly (shape_q updates on the same
  // edge) and takes priority over any step due in that clk.
  always_comb begin
    env_st_d   = env_st_q;
    env_d      = env_q;
    ediv_d     = ediv_q;
    env_step   = 1'b0;
    env_up     = (env_st_q == ENV_UP);
    env_at_end = env_up ? (env_q == 4'd15) : (env_q == 4'd0);
    if (shape_wr) begin
      ediv_d   = '0;
      env_d    = din[2] ? 4'd0 : 4'd15;
      env_st_d = din[2] ? ENV_UP : ENV_DOWN;
    end else if (env_tick) begin
      if (ediv_q >= eper_m1) begin
        ediv_d   = '0;
        env_step = 1'b1;
      end else begin
        ediv_d = ediv_q + 16'd1;
      end
      if (env_step && env_st_q != ENV_HOLD) begin
        if (!env_at_end) begin
          env_d = env_up ? env_q + 4'd1 : env_q - 4'd1;
        end else if (!shape_q[3]) begin
          env_d    = 4'd0;
          env_st_d = ENV_HOLD;
        end else if (shape_q[0]) begin
          env_d    = (env_up ? 4'd15 : 4'd0) ^ {4{shape_q[1]}};
          env_st_d = ENV_HOLD;
        end else if (shape_q[1]) begin
          env_st_d = env_up ? ENV_DOWN : ENV_UP;
        end else begin
          env_d = shape_q[2] ? 4'd0 : 4'd15;
        end
      end
    end
  end

  // ------------------------------------------------------------------- mixer
  logic [7:0] amp [CH];
  logic [3:0] lvl [CH];

  // level*17 on a 4-bit level is the nibble repeated.
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      lvl[i] = '0;
      if ((tone_q[i] | ~tone_en_q[i]) & (lfsr_q[0] | ~noise_en_q[i]))
        lvl[i] = vol_q[i][4] ? env_q : vol_q[i][3:0];
      amp[i] = {lvl[i], lvl[i]};
    end
  end

  // --------------------------------------------------------------- sequencer
  logic [SW-1:0]   slot_q;
  logic [10:0]     acc_q;
  logic [8*CH-1:0] shadow_q;
  logic [8*CH-1:0] chout_q;
  logic [10:0]     sound_q;
  logic            sv_q;
  logic [7:0]      amp_sel;

  always_comb begin
    amp_sel = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (slot_q == SW'(i)) amp_sel = amp[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q   <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      chout_q  <= '0;
      sound_q  <= '0;
      sv_q     <= 1'b0;
    end else begin
      sv_q <= 1'b0;
      if (cen) begin
        if (slot_q == SW'(CH)) begin
          sound_q <= acc_q;
          chout_q <= shadow_q;
          sv_q    <= 1'b1;
          acc_q   <= '0;
          slot_q  <= '0;
        end else begin
          acc_q <= acc_q + 11'(amp_sel);
          for (int unsigned i = 0; i < CH; i++) begin
            if (slot_q == SW'(i)) shadow_q[8*i +: 8] <= amp[i];
          end
          slot_q <= slot_q + SW'(1);
        end
      end
    end
  end

  assign dout         = dout_q;
  assign sound        = sound_q;
  assign ch_out       = chout_q;
  assign sample_valid = sv_q;

endmodule
